// File: rtl/line_mem_responder_if.sv
// Line memory port between a data cache (master) and the memory responder (slave).
// Carries one line request (read = refill, write = writeback) followed by a burst
// of 32-bit beats:
//   req_valid/req_ready/req_write/req_addr : line request handshake
//   rvalid/rready/rdata/rlast              : read burst, rlast marks the final beat
//   wvalid/wready/wdata                    : write burst
//   wdone                                  : one-cycle pulse, writeback committed
//   busy                                   : responder is not idle
interface line_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rlast;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        wdone;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, rready, wvalid, wdata,
    input  req_ready, rvalid, rdata, rlast, wready, wdone, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, rready, wvalid, wdata,
    output req_ready, rvalid, rdata, rlast, wready, wdone, busy
  );
endinterface

// File: rtl/line_mem_responder.sv
// Memory-side responder for the data cache refill/writeback port. Accepts one line
// request, waits LATENCY cycles, then moves the line as WORDS_PER_LINE 32-bit beats
// over a valid/ready burst against a word-addressed storage array.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rstn   : asynchronous active-low reset (storage contents are not reset)
//   bus_io : line_mem_responder_if.slave, request + read/write burst channels
module line_mem_responder #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned LATENCY        = 4
) (
  input logic                  clk,
  input logic                  rstn,
  line_mem_responder_if.slave  bus_io
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned BW = $clog2(WORDS_PER_LINE);
  localparam int unsigned LW = AW - BW;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BW-1:0] LastBeat = BW'(WORDS_PER_LINE - 1);
  localparam logic [CW-1:0] CntInit  = CW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRburst, StWburst} state_e;

  state_e        state_q;
  logic [LW-1:0] line_q;   // line index; word index is {line_q, beat}
  logic [BW-1:0] beat_q;
  logic [CW-1:0] cnt_q;
  logic          write_q;

  logic          req_ready_q;
  logic          rvalid_q;
  logic          rlast_q;
  logic [31:0]   rdata_q;
  logic          wready_q;
  logic          wdone_q;
  logic          busy_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [BW-1:0] beat_nxt;
  logic          mem_we;

  assign beat_nxt = beat_q + BW'(1);
  assign mem_we   = (state_q == StWburst) && bus_io.wvalid;

  // Storage array, deliberately without reset. A reset mid-burst forces the FSM out
  // of StWburst asynchronously, so no write can slip in while rstn is low.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[{line_q, beat_q}] <= bus_io.wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      line_q      <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
      wready_q    <= 1'b0;
      wdone_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wdone_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.req_valid) begin
            // Upper address bits above the array size are dropped, so lines wrap.
            line_q      <= bus_io.req_addr[AW+1:BW+2];
            write_q     <= bus_io.req_write;
            cnt_q       <= CntInit;
            state_q     <= StWait;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            beat_q <= '0;
            if (write_q) begin
              state_q  <= StWburst;
              wready_q <= 1'b1;
            end else begin
              state_q  <= StRburst;
              rvalid_q <= 1'b1;
              rlast_q  <= (LastBeat == '0);
              rdata_q  <= mem_q[{line_q, {BW{1'b0}}}];
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StRburst: begin
          // Without rready everything holds, keeping the presented beat stable.
          if (bus_io.rready) begin
            if (rlast_q) begin
              state_q     <= StIdle;
              rvalid_q    <= 1'b0;
              rlast_q     <= 1'b0;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              beat_q  <= beat_nxt;
              rlast_q <= (beat_nxt == LastBeat);
              rdata_q <= mem_q[{line_q, beat_nxt}];
            end
          end
        end
        StWburst: begin
          if (bus_io.wvalid) begin
            if (beat_q == LastBeat) begin
              state_q     <= StIdle;
              wready_q    <= 1'b0;
              wdone_q     <= 1'b1;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              beat_q <= beat_nxt;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.req_ready = req_ready_q;
  assign bus_io.rvalid    = rvalid_q;
  assign bus_io.rlast     = rlast_q;
  assign bus_io.rdata     = rdata_q;
  assign bus_io.wready    = wready_q;
  assign bus_io.wdone     = wdone_q;
  assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: directed scenarios plus randomized line traffic,
// checked by a scoreboard fed from a word-array reference model.
module tb_line_mem_responder;
  localparam int unsigned Depth = 1024;
  localparam int unsigned Wpl   = 4;
  localparam int unsigned Lat   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  line_mem_responder_if bus ();

  line_mem_responder #(
    .DEPTH_WORDS    (Depth),
    .WORDS_PER_LINE (Wpl),
    .LATENCY        (Lat)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [Depth];
  logic [31:0] exp_data_q [$];
  bit          exp_last_q [$];
  int          wdone_pending = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          first_pend = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [31:0] written_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word index of beat k of the line containing byte address addr.
  function automatic int unsigned widx(input logic [31:0] addr, input int k);
    int unsigned w;
    w = (addr >> 2) % Depth;
    w = w - (w % Wpl);
    return w + k;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every accepted read beat, checks stall
  // stability, wdone pulses and request-to-first-beat latency.
  initial forever begin
    logic [31:0] d;
    bit          l;
    @(negedge clk);
    if (!rstn) begin
      prev_stall = 0;
      first_pend = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_rvalid", bus.rvalid, 1);
        chk("stall_rdata", bus.rdata, prev_data);
        chk("stall_rlast", bus.rlast, prev_last);
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data 0x%08h, no beat expected", bus.rdata);
        end else begin
          d = exp_data_q.pop_front();
          l = exp_last_q.pop_front();
          chk("rdata", bus.rdata, d);
          chk("rlast", bus.rlast, l);
        end
      end
      if (bus.wdone) begin
        checks++;
        if (wdone_pending > 0) begin
          wdone_pending--;
        end else begin
          errors++;
          $display("FAIL unexpected_wdone: got wdone=1 expected 0 (t=%0t)", $time);
        end
      end
      if (first_pend && (bus.rvalid || bus.wready)) begin
        chk("first_beat_latency", cyc - acc_cyc, Lat + 1);
        first_pend = 0;
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc    = cyc;
        first_pend = 1;
      end
      prev_stall = bus.rvalid && !bus.rready;
      prev_data  = bus.rdata;
      prev_last  = bus.rlast;
    end
  end

  task automatic do_req(input bit wr, input logic [31:0] addr, output bit ok);
    int n  = 0;
    bit hs = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b0;
    ok = hs;
    chk("req_accept", {31'd0, hs}, 1);
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [31:0] d [4],
                            input logic [6:0] pat, input int plen, input bit poke,
                            input int stop_at);
    bit ok;
    int k = 0;
    int i = 0;
    int n = 0;
    do_req(1'b1, addr, ok);
    if (!ok) return;
    bus.wvalid = pat[0];
    bus.wdata  = d[0];
    while (k < stop_at && n < 200) begin
      @(negedge clk);
      if (poke && bus.req_valid) begin
        chk("busy_req_ready", bus.req_ready, 0);
        chk("busy_flag", bus.busy, 1);
      end
      if (bus.wready) begin
        if (bus.wvalid) begin
          ref_mem[widx(addr, k)] = bus.wdata;
          k++;
          if (k == Wpl) wdone_pending++;
        end
        i++;
      end
      @(posedge clk);
      #1;
      n++;
      bus.wvalid = (k < stop_at) ? pat[i % plen] : 1'b0;
      bus.wdata  = d[k % Wpl];
      if (poke) begin
        bus.req_valid = !bus.req_valid && (k < stop_at);
        bus.req_addr  = $urandom;
        bus.req_write = 1'($urandom % 2);
      end
    end
    bus.wvalid    = 1'b0;
    bus.req_valid = 1'b0;
    chk("write_beats", k, stop_at);
    if (stop_at == Wpl) begin
      written_q.push_back(addr);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("wdone_seen", wdone_pending, 0);
    end
  endtask

  task automatic read_line(input logic [31:0] addr, input logic [6:0] pat, input int plen);
    bit ok;
    int i = 0;
    int n = 0;
    bus.rready = pat[0];
    do_req(1'b0, addr, ok);
    if (!ok) return;
    for (int k = 0; k < Wpl; k++) begin
      exp_data_q.push_back(ref_mem[widx(addr, k)]);
      exp_last_q.push_back(k == Wpl - 1);
    end
    while (exp_data_q.size() > 0 && n < 300) begin
      @(negedge clk);
      if (bus.rvalid) i++;
      @(posedge clk);
      #1;
      n++;
      bus.rready = pat[i % plen];
    end
    chk("read_drain", exp_data_q.size(), 0);
    exp_data_q.delete();
    exp_last_q.delete();
    bus.rready = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_wdone", bus.wdone, 0);
    chk("rst_busy", bus.busy, 0);
    exp_data_q.delete();
    exp_last_q.delete();
    wdone_pending = 0;
    bus.req_valid = 1'b0;
    bus.wvalid    = 1'b0;
    bus.rready    = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] da [4];
    logic [31:0] db [4];
    logic [31:0] addr;
    logic [6:0]  pat;
    bit          ok;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.rready    = 1'b0;
    bus.wvalid    = 1'b0;
    bus.wdata     = '0;

    // Power-on reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("por_req_ready", bus.req_ready, 1);
    chk("por_rvalid", bus.rvalid, 0);
    chk("por_wready", bus.wready, 0);
    chk("por_busy", bus.busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-request (during the latency wait).
    do_req(1'b0, 32'h300, ok);
    @(posedge clk);
    #1;
    chk("busy_in_wait", bus.busy, 1);
    apply_reset();

    // Directed writeback then refill of the same line.
    da = '{32'h11, 32'h22, 32'h33, 32'h44};
    write_line(32'h40, da, 7'h7f, 1, 1'b0, 4);
    read_line(32'h4c, 7'h7f, 1);

    // Read with rready backpressure 1,0,0,1,1,0,1.
    read_line(32'h40, 7'b1011001, 7);

    // Write with wvalid gaps 1,0,1,0,0,1,1 while req_valid is poked.
    db = '{32'ha1, 32'hb2, 32'hc3, 32'hd4};
    write_line(32'h1c0, db, 7'b1100101, 7, 1'b1, 4);
    read_line(32'h1c0, 7'h7f, 1);

    // Address wrap past the array size.
    da = '{32'hcafe0001, 32'hcafe0002, 32'hcafe0003, 32'hcafe0004};
    write_line(32'h1020, da, 7'h7f, 1, 1'b0, 4);
    read_line(32'h20, 7'h7f, 1);
    chk("wrap_model", ref_mem[8], 32'hcafe0001);

    // Reset after the second writeback beat: beats 0,1 new, 2,3 old, no wdone.
    da = '{32'h0a0a0000, 32'h0a0a0001, 32'h0a0a0002, 32'h0a0a0003};
    db = '{32'h0b0b0000, 32'h0b0b0001, 32'h0b0b0002, 32'h0b0b0003};
    write_line(32'h80, da, 7'h7f, 1, 1'b0, 4);
    write_line(32'h80, db, 7'h7f, 1, 1'b0, 2);
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    read_line(32'h80, 7'h7f, 1);
    chk("abort_model_b1", ref_mem[33], 32'h0b0b0001);
    chk("abort_model_a2", ref_mem[34], 32'h0a0a0002);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      pat = 7'($urandom) | 7'h01;
      if (written_q.size() == 0 || ($urandom % 2) == 0) begin
        for (int k = 0; k < 4; k++) da[k] = $urandom;
        write_line($urandom, da, pat, $urandom_range(1, 7), 1'($urandom % 2), 4);
      end else begin
        addr = written_q[$urandom % written_q.size()];
        addr = {20'($urandom), addr[11:4], 4'($urandom)};
        read_line(addr, pat, $urandom_range(1, 7));
      end
      if (($urandom % 4) == 0) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue", exp_data_q.size(), 0);
    chk("final_wdone", wdone_pending, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
